// File: rtl/param_updown_counter.sv
// Parametrised up/down counter: modulus, clamped parallel load, synchronous clear,
// wrap or saturate at the boundaries, combinational terminal-count strobe and sticky overflow.
module param_updown_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MOD_VAL  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o
);

  // MOD_VAL may be 2^WIDTH (up to 2^32), so the maximum is derived in 64 bits.
  localparam longint unsigned MAX_CNT_L = MOD_VAL - 64'd1;
  localparam logic [WIDTH-1:0] MAX_CNT  = MAX_CNT_L[WIDTH-1:0];

  logic [WIDTH-1:0] count_q;
  logic             ovf_q;
  logic             at_max;
  logic             at_zero;
  logic             boundary;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] wrap_val;

  always_comb begin
    at_max       = (count_q == MAX_CNT);
    at_zero      = (count_q == '0);
    boundary     = (up_i & at_max) | (~up_i & at_zero);
    load_clamped = (load_val_i > MAX_CNT) ? MAX_CNT : load_val_i;
    wrap_val     = up_i ? '0 : MAX_CNT;
    tc_o         = rst_n_i & ~clr_i & ~load_i & en_i & boundary;
  end

  // Boundary is detected by explicit compare, never by natural 2^WIDTH rollover.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (load_i) begin
      count_q <= load_clamped;
    end else if (en_i) begin
      if (boundary) begin
        count_q <= SATURATE ? count_q : wrap_val;
        ovf_q   <= 1'b1;
      end else if (up_i) begin
        count_q <= count_q + WIDTH'(1);
      end else begin
        count_q <= count_q - WIDTH'(1);
      end
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: default wrap, MOD_VAL=10 wrap and saturate instances.
module tb_param_updown_counter;

  logic       clk_i = 1'b0;
  logic       rst_n_i, clr_i, load_i, en_i, up_i;
  logic [3:0] load_val_i;

  logic [3:0] count_def, count_m10, count_sat;
  logic       tc_def, tc_m10, tc_sat;
  logic       ovf_def, ovf_m10, ovf_sat;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  param_updown_counter u_def (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(clr_i), .load_i(load_i),
    .load_val_i(load_val_i), .en_i(en_i), .up_i(up_i),
    .count_o(count_def), .tc_o(tc_def), .ovf_o(ovf_def)
  );

  param_updown_counter #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1'b0)) u_m10 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(clr_i), .load_i(load_i),
    .load_val_i(load_val_i), .en_i(en_i), .up_i(up_i),
    .count_o(count_m10), .tc_o(tc_m10), .ovf_o(ovf_m10)
  );

  param_updown_counter #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1'b1)) u_sat (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clr_i(clr_i), .load_i(load_i),
    .load_val_i(load_val_i), .en_i(en_i), .up_i(up_i),
    .count_o(count_sat), .tc_o(tc_sat), .ovf_o(ovf_sat)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    clr_i = 1'b0; load_i = 1'b0; en_i = 1'b0; up_i = 1'b1; load_val_i = 4'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_i = 1'b0;
    en_i = 1'b1; up_i = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (tc_def !== 1'b0) begin
      errors++; $display("FAIL reset_tc got %0b exp 0", tc_def);
    end
    checks++;
    if ({count_def, count_m10, count_sat} !== 12'h000) begin
      errors++; $display("FAIL reset_count got %h/%h/%h exp 0/0/0", count_def, count_m10, count_sat);
    end
    checks++;
    if ({ovf_def, ovf_m10, ovf_sat} !== 3'b000) begin
      errors++; $display("FAIL reset_ovf got %b exp 000", {ovf_def, ovf_m10, ovf_sat});
    end
    rst_n_i = 1'b1;
    idle_inputs();
  endtask

  task automatic test_wrap_up();
    logic [3:0] exp_cnt;
    do_reset();
    en_i = 1'b1; up_i = 1'b1;
    exp_cnt = 4'd0;
    for (int i = 0; i < 17; i++) begin
      #1;
      checks++;
      if (tc_def !== (exp_cnt == 4'd15)) begin
        errors++; $display("FAIL wrap_up_tc step %0d got %0b exp %0b", i, tc_def, exp_cnt == 4'd15);
      end
      tick();
      exp_cnt = (exp_cnt == 4'd15) ? 4'd0 : exp_cnt + 4'd1;
      checks++;
      if (count_def !== exp_cnt || ovf_def !== (i >= 15)) begin
        errors++;
        $display("FAIL wrap_up_cnt step %0d got %0d/%0b exp %0d/%0b", i, count_def, ovf_def, exp_cnt, i >= 15);
      end
    end
    en_i = 1'b0;
    tick();
    checks++;
    if (count_def !== 4'd1 || ovf_def !== 1'b1) begin
      errors++; $display("FAIL hold got %0d/%0b exp 1/1", count_def, ovf_def);
    end
  endtask

  task automatic test_down_mod10();
    logic [3:0] exp_seq [5] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
    do_reset();
    en_i = 1'b1; up_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (tc_m10 !== (i == 0)) begin
        errors++; $display("FAIL down_tc step %0d got %0b exp %0b", i, tc_m10, i == 0);
      end
      tick();
      checks++;
      if (count_m10 !== exp_seq[i] || ovf_m10 !== 1'b1) begin
        errors++; $display("FAIL down_cnt step %0d got %0d/%0b exp %0d/1", i, count_m10, ovf_m10, exp_seq[i]);
      end
    end
  endtask

  task automatic test_updown_mod10();
    do_reset();
    load_i = 1'b1; load_val_i = 4'd8;
    tick();
    load_i = 1'b0; en_i = 1'b1; up_i = 1'b1;
    tick();
    #1;
    checks++;
    if (count_m10 !== 4'd9 || tc_m10 !== 1'b1 || ovf_m10 !== 1'b0) begin
      errors++; $display("FAIL up_to_max got %0d/%0b/%0b exp 9/1/0", count_m10, tc_m10, ovf_m10);
    end
    tick();
    checks++;
    if (count_m10 !== 4'd0 || ovf_m10 !== 1'b1) begin
      errors++; $display("FAIL up_wrap got %0d/%0b exp 0/1", count_m10, ovf_m10);
    end
    tick();
    up_i = 1'b0;
    tick();
    checks++;
    if (count_m10 !== 4'd0) begin
      errors++; $display("FAIL dir_change got %0d exp 0", count_m10);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_seq [5] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    logic       exp_ovf [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_tc  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    load_i = 1'b1; load_val_i = 4'd7;
    tick();
    load_i = 1'b0; en_i = 1'b1; up_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (tc_sat !== exp_tc[i]) begin
        errors++; $display("FAIL sat_tc step %0d got %0b exp %0b", i, tc_sat, exp_tc[i]);
      end
      tick();
      checks++;
      if (count_sat !== exp_seq[i] || ovf_sat !== exp_ovf[i]) begin
        errors++;
        $display("FAIL sat_cnt step %0d got %0d/%0b exp %0d/%0b", i, count_sat, ovf_sat, exp_seq[i], exp_ovf[i]);
      end
    end
    clr_i = 1'b1; en_i = 1'b0;
    tick();
    clr_i = 1'b0; en_i = 1'b1; up_i = 1'b0;
    #1;
    checks++;
    if (tc_sat !== 1'b1) begin
      errors++; $display("FAIL sat_tc_zero got %0b exp 1", tc_sat);
    end
    tick();
    checks++;
    if (count_sat !== 4'd0 || ovf_sat !== 1'b1) begin
      errors++; $display("FAIL sat_hold_zero got %0d/%0b exp 0/1", count_sat, ovf_sat);
    end
  endtask

  task automatic test_load_clamp();
    do_reset();
    en_i = 1'b1; up_i = 1'b0;
    tick();
    load_i = 1'b1; load_val_i = 4'd12; up_i = 1'b1;
    #1;
    checks++;
    if (tc_m10 !== 1'b0) begin
      errors++; $display("FAIL load_tc got %0b exp 0", tc_m10);
    end
    tick();
    checks++;
    if (count_m10 !== 4'd9 || ovf_m10 !== 1'b1) begin
      errors++; $display("FAIL load_clamp got %0d/%0b exp 9/1", count_m10, ovf_m10);
    end
    load_val_i = 4'd3;
    tick();
    checks++;
    if (count_m10 !== 4'd3 || ovf_m10 !== 1'b1) begin
      errors++; $display("FAIL load_3 got %0d/%0b exp 3/1", count_m10, ovf_m10);
    end
    load_val_i = 4'd10;
    tick();
    checks++;
    if (count_m10 !== 4'd9 || count_def !== 4'd10) begin
      errors++; $display("FAIL load_10 got %0d/%0d exp 9/10", count_m10, count_def);
    end
    load_i = 1'b0; en_i = 1'b0;
  endtask

  task automatic test_clr_priority();
    load_i = 1'b1; load_val_i = 4'd5;
    tick();
    clr_i = 1'b1; load_i = 1'b1; load_val_i = 4'd7; en_i = 1'b1; up_i = 1'b1;
    #1;
    checks++;
    if (count_m10 !== 4'd5 || ovf_m10 !== 1'b1 || tc_m10 !== 1'b0) begin
      errors++; $display("FAIL clr_pre got %0d/%0b/%0b exp 5/1/0", count_m10, ovf_m10, tc_m10);
    end
    tick();
    checks++;
    if (count_m10 !== 4'd0 || ovf_m10 !== 1'b0) begin
      errors++; $display("FAIL clr_all got %0d/%0b exp 0/0", count_m10, ovf_m10);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_i = 1'b1; load_val_i = 4'd5;
    tick();
    load_i = 1'b0; en_i = 1'b1; up_i = 1'b1;
    tick();
    checks++;
    if (count_def !== 4'd6) begin
      errors++; $display("FAIL mid_pre got %0d exp 6", count_def);
    end
    rst_n_i = 1'b0; load_i = 1'b1; load_val_i = 4'd3;
    #1;
    checks++;
    if (tc_def !== 1'b0) begin
      errors++; $display("FAIL mid_tc got %0b exp 0", tc_def);
    end
    tick();
    checks++;
    if (count_def !== 4'd0 || ovf_def !== 1'b0) begin
      errors++; $display("FAIL mid_rst got %0d/%0b exp 0/0", count_def, ovf_def);
    end
    rst_n_i = 1'b1; load_i = 1'b0;
    tick();
    checks++;
    if (count_def !== 4'd1) begin
      errors++; $display("FAIL mid_resume got %0d exp 1", count_def);
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    idle_inputs();
    test_reset();
    test_wrap_up();
    test_down_mod10();
    test_updown_mod10();
    test_saturate();
    test_load_clamp();
    test_clr_priority();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
